// File: rtl/sevenseg_scan_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sevenseg_scan_mux
//  Description : Time-multiplexed driver for an N-digit common-anode
//                seven-segment display. A load strobe captures an N-nibble
//                hex value plus per-digit decimal-point and blank requests
//                into shadow registers. One digit is scanned per refresh slot.
//                Each slot starts with a guard interval in which all anodes
//                are off, which suppresses ghosting between digits. All pin
//                outputs are registered and active-low.
//
//  Parameters  : NUM_DIGITS   - digits scanned (1..8)
//                REFRESH_DIV  - clock cycles per digit slot (>= GUARD_CYCLES+2)
//                GUARD_CYCLES - all-off cycles at the start of each slot (0 ok)
//
//  Ports       : clk    in   system clock
//                reset  in   asynchronous active-high reset
//                value  in   hex nibbles, nibble k drives digit k (0 = rightmost)
//                dp_in  in   decimal-point request per digit (1 = lit)
//                blank  in   per-digit blank request (1 = dark)
//                load   in   strobe capturing value/dp_in/blank
//                an     out  anode enables, active-low
//                seg    out  segments gfedcba, active-low
//                dp     out  decimal point, active-low
//
//  Options     : define SEVENSEG_ZERO_SUPPRESS_EN to enable leading-zero
//                suppression.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    // ------------------------------------------------------------------------
    // Hex to active-low gfedcba decode
    // ------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h18;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // Shadow registers
    // ------------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   blank_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            dp_q    <= '0;
            blank_q <= '0;
        end else if (load) begin
            value_q <= value;
            dp_q    <= dp_in;
            blank_q <= blank;
        end
    end

    // ------------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wrap_w;

    always_comb begin
        wrap_w = (cnt_q == CNT_LAST);
        cnt_d  = cnt_q + 1'b1;
        idx_d  = idx_q;
        if (wrap_w) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // ------------------------------------------------------------------------
    // Guard phase: the first GUARD_CYCLES counts of every slot
    // ------------------------------------------------------------------------
    logic guard_w;

    generate
        if (GUARD_CYCLES == 0) begin : g_no_guard
            assign guard_w = 1'b0;
        end else begin : g_guard
            assign guard_w = (cnt_q < CNT_W'(GUARD_CYCLES));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Leading-zero suppression mask
    // ------------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] supp_w;

`ifdef SEVENSEG_ZERO_SUPPRESS_EN
    // Walk from the most significant digit down. A digit stays suppressed only
    // while every nibble from the top down to it is zero and none of those
    // digits requests a decimal point; digit 0 is never suppressed.
    logic lead_w;

    always_comb begin
        supp_w = '0;
        lead_w = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lead_w    = lead_w & (value_q[4*k +: 4] == 4'h0) & ~dp_q[k];
            supp_w[k] = lead_w;
        end
    end
`else
    assign supp_w = '0;
`endif

    // ------------------------------------------------------------------------
    // Current-digit selection and registered outputs
    // ------------------------------------------------------------------------
    logic [3:0]            nib_w;
    logic                  blank_w;
    logic                  dpsel_w;
    logic                  supsel_w;
    logic [NUM_DIGITS-1:0] onehot_w;
    logic                  show_w;
    logic [NUM_DIGITS-1:0] an_d, an_q;
    logic [6:0]            seg_d, seg_q;
    logic                  dp_d, dp_q_o;

    always_comb begin
        nib_w    = '0;
        blank_w  = 1'b0;
        dpsel_w  = 1'b0;
        supsel_w = 1'b0;
        onehot_w = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_w       = value_q[4*k +: 4];
                blank_w     = blank_q[k];
                dpsel_w     = dp_q[k];
                supsel_w    = supp_w[k];
                onehot_w[k] = 1'b1;
            end
        end

        show_w = ~guard_w & ~blank_w & ~supsel_w;

        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (show_w) begin
            an_d  = ~onehot_w;
            seg_d = hex_to_seg(nib_w);
            dp_d  = ~dpsel_w;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q   <= '1;
            seg_q  <= SEG_OFF;
            dp_q_o <= 1'b1;
        end else begin
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q_o <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q_o;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sevenseg_scan_mux
//  Description : Self-checking bench for sevenseg_scan_mux with
//                NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2. Every cycle is
//                checked against a scoreboard queue; a vector table checks
//                each digit's decoded segments, and hand-written sequences
//                cover the reset lead-in, load timing and mid-scan reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan_mux;

    localparam int ND  = 4;
    localparam int DIV = 8;
    localparam int GC  = 2;
    localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    sevenseg_scan_mux #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (DIV),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .dp_in (dp_in),
        .blank (blank),
        .load  (load),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Bench view of the scan position and shadow contents
    int          m_pc;
    int          m_slot;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    int          last_pc;
    int          last_slot;
    logic [11:0] sb_q[$];

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dpi;
        logic [3:0]  blk;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  dark;   // 1 = slot fully dark
        logic [3:0]  dpo;    // expected dp pin per slot
    } vec_t;
    vec_t vecs[$];

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
            4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
            4'h8: s = 7'h00; 4'h9: s = 7'h18; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
            4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [11:0] model_out();
        logic       show;
        logic [3:0] oh;
        logic [3:0] nib;
        logic       z;
        oh         = '0;
        oh[m_slot] = 1'b1;
        nib        = m_val[4*m_slot +: 4];
        show       = (m_pc >= GC) && !m_blank[m_slot];
`ifdef SEVENSEG_ZERO_SUPPRESS_EN
        if (m_slot != 0) begin
            z = 1'b1;
            for (int j = m_slot; j < ND; j++)
                if (m_val[4*j +: 4] != 4'h0 || m_dp[j]) z = 1'b0;
            if (z) show = 1'b0;
        end
`else
        z = 1'b0;
        if (z) show = 1'b0;
`endif
        if (show) return {~oh, seg_of(nib), ~m_dp[m_slot]};
        return DARK;
    endfunction

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                      name, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_slot  = 0;
        m_val   = '0;
        m_dp    = '0;
        m_blank = '0;
        sb_q.delete();
    endtask

    // One clock: expectation queued before the edge, compared after it
    task automatic step();
        logic [11:0] e;
        e = model_out();
        sb_q.push_back(e);
        last_pc   = m_pc;
        last_slot = m_slot;
        @(posedge clk);
        if (load) begin
            m_val   = value;
            m_dp    = dp_in;
            m_blank = blank;
        end
        if (m_pc == DIV - 1) begin
            m_pc   = 0;
            m_slot = (m_slot + 1) % ND;
        end else begin
            m_pc++;
        end
        @(negedge clk);
        e = sb_q.pop_front();
        chk("scan", {an, seg, dp}, e);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_until(input int pc, input int slot);
        int k;
        k = 0;
        while (!(m_pc == pc && m_slot == slot) && k < 64) begin
            step();
            k++;
        end
        if (k >= 64) begin
            n_total++;
            $display("FAIL run_until: position pc=%0d slot=%0d not reached", pc, slot);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v;
        dp_in = d;
        blank = b;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    // Called right after reset release, at a falling edge
    task automatic lead_in(input string name);
        chk(name, {an, seg, dp}, DARK);
        for (int i = 0; i < 9; i++) begin
            step();
            chk(name, {an, seg, dp}, (i < 2 || i == 8) ? DARK : {4'hE, 7'h40, 1'b1});
        end
    endtask

    initial begin
        vecs.push_back('{16'h1A2F, 4'b0100, 4'b0000,
                         {7'h79, 7'h08, 7'h24, 7'h0E}, 4'b0000, 4'b1011});
        vecs.push_back('{16'h3C6E, 4'b0000, 4'b0010,
                         {7'h30, 7'h46, 7'h7F, 7'h06}, 4'b0010, 4'b1111});
        vecs.push_back('{16'h8059, 4'b1001, 4'b0000,
                         {7'h00, 7'h40, 7'h12, 7'h18}, 4'b0000, 4'b0110});
        vecs.push_back('{16'h47BD, 4'b0000, 4'b1100,
                         {7'h7F, 7'h7F, 7'h03, 7'h21}, 4'b1100, 4'b1111});
`ifdef SEVENSEG_ZERO_SUPPRESS_EN
        vecs.push_back('{16'h0050, 4'b0000, 4'b0000,
                         {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1100, 4'b1111});
        vecs.push_back('{16'h0000, 4'b0000, 4'b0000,
                         {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110, 4'b1111});
        vecs.push_back('{16'h0050, 4'b0100, 4'b0000,
                         {7'h7F, 7'h40, 7'h12, 7'h40}, 4'b1000, 4'b1011});
`else
        vecs.push_back('{16'h0050, 4'b0000, 4'b0000,
                         {7'h40, 7'h40, 7'h12, 7'h40}, 4'b0000, 4'b1111});
`endif

        reset = 1'b1;
        load  = 1'b0;
        value = '0;
        dp_in = '0;
        blank = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", {an, seg, dp}, DARK);
        reset = 1'b0;

        // Dark lead-in, first digit, then the rest of the scan order
        lead_in("lead_in");
        run(24);

        // Table: load each vector, then check every slot mid-active
        foreach (vecs[vi]) begin
            logic [3:0]  oh;
            logic [11:0] exp;
            pulse_load(vecs[vi].v, vecs[vi].dpi, vecs[vi].blk);
            for (int c = 0; c < 32; c++) begin
                step();
                if (last_pc == 4) begin
                    oh            = '0;
                    oh[last_slot] = 1'b1;
                    exp = vecs[vi].dark[last_slot] ? DARK :
                          {~oh, vecs[vi].segs[7*last_slot +: 7], vecs[vi].dpo[last_slot]};
                    chk($sformatf("vec%0d_slot%0d", vi, last_slot), {an, seg, dp}, exp);
                end
            end
        end

        // Inputs change without load: nothing visible
        pulse_load(16'h1A2F, 4'b0100, 4'b0000);
        value = 16'hFFFF;
        dp_in = 4'hF;
        blank = 4'hF;
        run(32);

        // Load on the last prescaler cycle of slot 1 feeds slot 2 directly
        run_until(7, 1);
        pulse_load(16'h157F, 4'b0000, 4'b0000);
        step();
        chk("slot2_guard", {an, seg, dp}, DARK);
        step();
        chk("slot2_guard", {an, seg, dp}, DARK);
        step();
        chk("slot2_first_active", {an, seg, dp}, {4'hB, 7'h12, 1'b1});

        // Asynchronous reset in the active phase of slot 2
        run_until(4, 2);
        #2 reset = 1'b1;
        #1 chk("async_reset", {an, seg, dp}, DARK);
        @(negedge clk);
        chk("reset_held", {an, seg, dp}, DARK);
        reset = 1'b0;
        model_reset();
        lead_in("restart");
        run(16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
